// File: rtl/afifo_1clk_if.sv
// Producer/consumer handshake bundle for the single-clock FIFO.
// The master side drives push/pop requests; the slave side is the FIFO.
interface afifo_1clk_if #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 2
);
    logic             i_wr;
    logic [DSIZE-1:0] i_wdata;
    logic             o_wfull;
    logic             i_rd;
    logic [DSIZE-1:0] o_rdata;
    logic             o_rempty;
    logic [ASIZE:0]   o_count;
    logic             o_overflow;
    logic             o_underflow;

    modport master (
        output i_wr, i_wdata, i_rd,
        input  o_wfull, o_rdata, o_rempty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_wr, i_wdata, i_rd,
        output o_wfull, o_rdata, o_rempty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/afifo_1clk.sv
// Single-clock circular-buffer FIFO with first-word-fall-through read data,
// occupancy count and sticky overflow/underflow flags.
module afifo_1clk #(
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    afifo_1clk_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned PW    = ASIZE + 1;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             empty_c;
    logic             full_c;
    logic             wr_en_c;
    logic             rd_en_c;

    // Flags from registered pointers only, so requests never reach outputs combinationally.
    always_comb begin
        empty_c     = 1'b0;
        full_c      = 1'b0;
        wr_en_c     = 1'b0;
        rd_en_c     = 1'b0;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        empty_c = (wptr_q == rptr_q);
        full_c  = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) &&
                  (wptr_q[ASIZE] != rptr_q[ASIZE]);

        wr_en_c = bus.i_wr && !full_c && !i_rst;
        rd_en_c = bus.i_rd && !empty_c;

        wptr_d      = wptr_q + PW'(wr_en_c);
        rptr_d      = rptr_q + PW'(rd_en_c);
        overflow_d  = overflow_q  | (bus.i_wr && full_c);
        underflow_d = underflow_q | (bus.i_rd && empty_c);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately not reset; stale words are hidden by the pointers.
    always_ff @(posedge i_clk) begin
        if (wr_en_c) begin
            mem_q[wptr_q[ASIZE-1:0]] <= bus.i_wdata;
        end
    end

    assign bus.o_wfull     = full_c;
    assign bus.o_rempty    = empty_c;
    assign bus.o_count     = wptr_q - rptr_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
    assign bus.o_rdata     = empty_c ? '0 : mem_q[rptr_q[ASIZE-1:0]];

endmodule

// File: tb/tb_afifo_1clk.sv
// Self-checking bench for afifo_1clk: directed vector table plus randomized
// traffic compared against a queue-based reference model.
module tb_afifo_1clk;
    localparam int unsigned DSIZE = 8;
    localparam int unsigned ASIZE = 2;
    localparam int unsigned DEPTH = 1 << ASIZE;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    afifo_1clk_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

    afifo_1clk #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] wdata;
        logic [2:0] count;
        logic       empty;
        logic       full;
        logic [7:0] rdata;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic w, input logic d, input logic [7:0] wd,
                       input logic [2:0] c, input logic e, input logic f,
                       input logic [7:0] rdv, input logic o, input logic u);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = d; v.wdata = wd;
        v.count = c; v.empty = e; v.full = f; v.rdata = rdv; v.ovf = o; v.unf = u;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_step(input logic r, input logic w, input logic d, input logic [7:0] wd);
        rst         = r;
        bus.i_wr    = w;
        bus.i_rd    = d;
        bus.i_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] c, input logic e,
                                 input logic f, input logic [7:0] rdv,
                                 input logic o, input logic u);
        chk($sformatf("%s count", tag), 32'(bus.o_count), 32'(c));
        chk($sformatf("%s empty", tag), 32'(bus.o_rempty), 32'(e));
        chk($sformatf("%s full", tag), 32'(bus.o_wfull), 32'(f));
        chk($sformatf("%s rdata", tag), 32'(bus.o_rdata), 32'(rdv));
        chk($sformatf("%s overflow", tag), 32'(bus.o_overflow), 32'(o));
        chk($sformatf("%s underflow", tag), 32'(bus.o_underflow), 32'(u));
    endtask

    // Reference model state
    logic [7:0] model_q[$];
    logic       m_ovf;
    logic       m_unf;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_wr = 1'b0;
        bus.i_rd = 1'b0;
        bus.i_wdata = 8'h00;

        //    rst wr rd wdata  cnt e f rdata ovf unf
        // Reset with write held, then release
        add(1, 1, 0, 8'h11, 0, 1, 0, 8'h00, 0, 0);
        add(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Three writes then three reads
        add(0, 1, 0, 8'hAA, 1, 0, 0, 8'hAA, 0, 0);
        add(0, 1, 0, 8'hBB, 2, 0, 0, 8'hAA, 0, 0);
        add(0, 1, 0, 8'hCC, 3, 0, 0, 8'hAA, 0, 0);
        add(0, 0, 1, 8'h00, 2, 0, 0, 8'hBB, 0, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 8'hCC, 0, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Fill across pointer wrap, overflow, drain, underflow
        add(0, 1, 0, 8'hDD, 1, 0, 0, 8'hDD, 0, 0);
        add(0, 1, 0, 8'hDD, 2, 0, 0, 8'hDD, 0, 0);
        add(0, 1, 0, 8'hDD, 3, 0, 0, 8'hDD, 0, 0);
        add(0, 1, 0, 8'hDD, 4, 0, 1, 8'hDD, 0, 0);
        add(0, 1, 0, 8'hFF, 4, 0, 1, 8'hDD, 1, 0);
        add(0, 0, 1, 8'h00, 3, 0, 0, 8'hDD, 1, 0);
        add(0, 0, 1, 8'h00, 2, 0, 0, 8'hDD, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 8'hDD, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        // Simultaneous rd+wr at count 2, then at full
        add(0, 1, 0, 8'h01, 1, 0, 0, 8'h01, 0, 0);
        add(0, 1, 0, 8'h02, 2, 0, 0, 8'h01, 0, 0);
        add(0, 1, 1, 8'h5A, 2, 0, 0, 8'h02, 0, 0);
        add(0, 1, 1, 8'h5A, 2, 0, 0, 8'h5A, 0, 0);
        add(0, 1, 1, 8'h5A, 2, 0, 0, 8'h5A, 0, 0);
        add(0, 1, 0, 8'h03, 3, 0, 0, 8'h5A, 0, 0);
        add(0, 1, 0, 8'h04, 4, 0, 1, 8'h5A, 0, 0);
        add(0, 1, 1, 8'h66, 3, 0, 0, 8'h5A, 1, 0);
        add(0, 0, 1, 8'h00, 2, 0, 0, 8'h03, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 8'h04, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 0);
        // Reset mid-operation with read held, then write 77
        add(0, 1, 0, 8'h10, 1, 0, 0, 8'h10, 1, 0);
        add(0, 1, 0, 8'h20, 2, 0, 0, 8'h10, 1, 0);
        add(0, 1, 0, 8'h30, 3, 0, 0, 8'h10, 1, 0);
        add(0, 0, 1, 8'h00, 2, 0, 0, 8'h20, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 8'h30, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 1, 1);
        add(0, 1, 0, 8'h41, 1, 0, 0, 8'h41, 1, 1);
        add(0, 1, 0, 8'h42, 2, 0, 0, 8'h41, 1, 1);
        add(0, 1, 0, 8'h43, 3, 0, 0, 8'h41, 1, 1);
        add(1, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0);
        add(0, 1, 0, 8'h77, 1, 0, 0, 8'h77, 0, 0);
        add(0, 0, 1, 8'h00, 0, 1, 0, 8'h00, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].wdata);
            check_outputs($sformatf("vec%0d", i), vecs[i].count, vecs[i].empty,
                          vecs[i].full, vecs[i].rdata, vecs[i].ovf, vecs[i].unf);
        end

        // Randomized traffic against a queue model; start from a clean reset.
        drive_step(1'b1, 1'b0, 1'b0, 8'h00);
        model_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic       r, w, d;
            logic [7:0] wd;
            int         sz;
            logic [7:0] exp_rd;
            r  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 99) < 55);
            d  = ($urandom_range(0, 99) < 50);
            wd = 8'($urandom);
            drive_step(r, w, d, wd);
            sz = model_q.size();
            if (r) begin
                model_q.delete();
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end else begin
                if (w && sz == DEPTH) m_ovf = 1'b1;
                if (d && sz == 0)     m_unf = 1'b1;
                if (d && sz > 0)      void'(model_q.pop_front());
                if (w && sz < DEPTH)  model_q.push_back(wd);
            end
            exp_rd = (model_q.size() > 0) ? model_q[0] : 8'h00;
            check_outputs($sformatf("rnd%0d", n), 3'(model_q.size()),
                          model_q.size() == 0, model_q.size() == DEPTH,
                          exp_rd, m_ovf, m_unf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/afifo_1clk.md
Name: afifo_1clk

Overview:
- Single-clock, parameterised circular-buffer FIFO with first-word-fall-through read data.
- Sits between a producer and a consumer in the same clock domain and provides full/empty flags, an occupancy count, and sticky overflow/underflow error flags.
- Depth is 2^ASIZE entries of DSIZE bits each.

Parameters:
- DSIZE, 8, data word width in bits.
- ASIZE, 2, address width; depth = 2^ASIZE (default 4 entries).

Ports:
- i_clk  input  1  single clock; all state changes on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_wr  input  1  write request (push).
- i_wdata  input  DSIZE  write data.
- o_wfull  output  1  FIFO full.
- i_rd  input  1  read request (pop).
- o_rdata  output  DSIZE  head-of-FIFO data (first-word fall-through).
- o_rempty  output  1  FIFO empty.
- o_count  output  ASIZE+1  number of stored entries, 0..2^ASIZE.
- o_overflow  output  1  sticky: write attempted while full.
- o_underflow  output  1  sticky: read attempted while empty.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - write/read pointers, o_count, o_overflow and o_underflow go to 0; o_rempty=1, o_wfull=0, o_rdata=0.
  - Memory contents are not cleared.
  - Reset has priority over i_wr/i_rd in the same cycle, including mid-operation; all stored data is discarded.
- Pointers are ASIZE+1-bit binary (extra wrap bit); the memory address is the low ASIZE bits. Pointers wrap modulo 2^(ASIZE+1).
- Flags are combinational from the registered pointers:
  - empty = (wptr == rptr).
  - full = (low bits equal and wrap bits differ).
  - o_count = wptr - rptr, modulo 2^(ASIZE+1).
- Write accept: i_wr && !o_wfull, using the pre-edge flag. On accept, mem[wptr] <= i_wdata and wptr increments. Flags and count reflect the write immediately after that edge.
- Read accept: i_rd && !o_rempty, using the pre-edge flag. On accept, rptr increments.
- o_rdata = mem[rptr] combinationally while not empty, and 0 while o_rempty=1. The head word is visible before i_rd is asserted. Data appears at o_rdata the cycle after it is written into an empty FIFO (zero-cycle fall-through is not required).
- Simultaneous i_wr and i_rd:
  - Each is qualified independently against pre-edge flags.
  - Not empty and not full: both occur and o_count is unchanged.
  - Full: only the read occurs and the write is dropped (counts as overflow).
  - Empty: only the write occurs and the read is ignored (counts as underflow).
- Overflow/underflow:
  - i_wr while o_wfull sets o_overflow; i_rd while o_rempty sets o_underflow.
  - Both stay set until reset. A dropped write never modifies memory or pointers.
- Ordering: strict first-in first-out across pointer wrap-around.
- No combinational path from i_wr/i_rd to any output.

Test Plan:
- Reset with i_wr=1 held → o_rempty=1, o_wfull=0, o_count=0, o_rdata=8'h00, no write occurs; release reset → still empty.
- Write AA, BB, CC on 3 consecutive edges → o_count=3, o_rempty=0, o_wfull=0, o_rdata=AA. Assert i_rd 3 cycles → o_rdata shows BB, then CC, then 00 with o_rempty=1 and o_count=0.
- Write DD on 4 edges (pointers wrap past index 3) → o_wfull=1, o_count=4. A 5th write of FF is dropped: o_overflow=1, count stays 4. Read 4 times → DD each time, o_wfull clears after the first read, o_rempty=1 after the fourth; a 5th read sets o_underflow=1 and o_rdata=00.
- At count 2, assert i_rd and i_wr (data 5A) together for 3 cycles → o_count stays 2 and the output sequence preserves write order. At full, rd+wr together → count drops to 3, write dropped, o_overflow=1.
- Fill to 3 entries, then assert i_rst for 1 cycle with i_rd=1 → next cycle o_count=0, o_rempty=1, flags and sticky errors cleared; a subsequent write of 77 reads back as 77.
